transpose_read_streamer: RTL and testbench

- Downstream read sequencer for the 4x4 circulant transpose store.
- On `start`, walks the stored matrix and issues one read address per element to the store's read port.
- Returns the data as a valid/ready stream, in transposed (column-major) or normal (row-major) order.
- A 2-entry output buffer absorbs consumer backpressure without dropping in-flight reads.

---
 rtl/transpose_read_streamer_pkg.sv | 13 +
 rtl/transpose_read_streamer_if.sv | 18 +
 rtl/transpose_read_streamer_stream_skid_fifo2.sv | 31 +++
 rtl/transpose_read_streamer.sv | 81 ++++++++
 tb/tb_transpose_read_streamer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/transpose_read_streamer_pkg.sv
// transpose_read_streamer_pkg: constants shared with the store, FSM states and buffer entry type
package transpose_read_streamer_pkg;
  localparam int N = 4;
  localparam int IDX_W = 2;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic              last;
  } entry_t;
endpackage

// File: rtl/transpose_read_streamer_if.sv
// transpose_read_streamer_if: store read port plus output element stream
interface transpose_read_streamer_if;
  import transpose_read_streamer_pkg::*;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_row;
  logic [IDX_W-1:0]  rd_col;
  logic [DATA_W-1:0] rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [IDX_W-1:0]  m_row;
  logic [IDX_W-1:0]  m_col;
  logic              m_last;
  modport master (output rd_en, rd_row, rd_col, m_valid, m_data, m_row, m_col, m_last,
                  input rd_data, m_ready);
  modport slave (input rd_en, rd_row, rd_col, m_valid, m_data, m_row, m_col, m_last,
                 output rd_data, m_ready);
endinterface

// File: rtl/transpose_read_streamer_stream_skid_fifo2.sv
// stream_skid_fifo2: 2-entry valid/ready FIFO, head output zeroed while empty
module stream_skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   cnt
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  assign valid = cnt != 2'd0;
  assign dout = valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= 2'd0;
      wp <= 1'b0;
      rp <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop && valid) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop && valid);
    end
endmodule

// File: rtl/transpose_read_streamer.sv
// transpose_read_streamer: walks the 4x4 store and streams it row- or column-major
module transpose_read_streamer
  import transpose_read_streamer_pkg::*;
#(
  parameter int RD_LAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic transpose,
  output logic busy,
  output logic done,
  transpose_read_streamer_if.master bus
);
  localparam int KW = 2*IDX_W+1;
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [IDX_W-1:0] i, j;
  logic [2:0] occ;
  logic [1:0] cnt;
  logic tr, infl, pop, push, credit, last_k;
  entry_t din, head;
  assign i = k[2*IDX_W-1:IDX_W];
  assign j = k[IDX_W-1:0];
  assign last_k = k == KW'(N*N-1);
  assign pop = bus.m_valid && bus.m_ready;
  assign occ = 3'(cnt) + 3'(infl) - 3'((RD_LAT == 1) && pop);
  assign credit = occ < 3'd2;
  assign bus.rd_row = bus.rd_en ? (tr ? j : i) : '0;
  assign bus.rd_col = bus.rd_en ? (tr ? i : j) : '0;
  assign bus.m_data = head.data;
  assign bus.m_row = head.row;
  assign bus.m_col = head.col;
  assign bus.m_last = head.last;
  always_comb begin
    bus.rd_en = (state == ISSUE) && credit;
    busy = (state == ISSUE) || (state == DRAIN);
    done = state == DONE;
    state_n = state == IDLE  ? (start ? ISSUE : IDLE) :
              state == ISSUE ? (bus.rd_en && last_k ? DRAIN : ISSUE) :
              state == DRAIN ? (pop && head.last ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      tr <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        k <= '0;
        tr <= transpose;
      end else if (bus.rd_en) k <= k + 1'b1;
    end
  if (RD_LAT == 0) begin : g_lat0
    assign infl = 1'b0;
    assign push = bus.rd_en;
    assign din = '{data: bus.rd_data, row: i, col: j, last: last_k};
  end else begin : g_lat1
    logic [IDX_W-1:0] p_row, p_col;
    logic p_last;
    always_ff @(posedge clk)
      if (!rst_n) begin
        infl <= 1'b0;
        p_row <= '0;
        p_col <= '0;
        p_last <= 1'b0;
      end else begin
        infl <= bus.rd_en;
        p_row <= i;
        p_col <= j;
        p_last <= last_k;
      end
    assign push = infl;
    assign din = '{data: bus.rd_data, row: p_row, col: p_col, last: p_last};
  end
  stream_skid_fifo2 #(.W($bits(entry_t))) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .din(din), .pop(pop),
    .dout(head), .valid(bus.m_valid), .cnt(cnt)
  );
endmodule

// File: tb/tb_transpose_read_streamer.sv
// tb_transpose_read_streamer: scoreboard bench driving RD_LAT=0 and RD_LAT=1 instances in lockstep
module tb_transpose_read_streamer;
  typedef struct packed {
    logic [7:0] data;
    logic [1:0] row;
    logic [1:0] col;
    logic       last;
  } exp_t;
  typedef struct {
    bit         tr;
    bit         rnd;
    int         hold;
    bit         repulse;
    logic [7:0] e1;
    logic [7:0] e15;
    int         span;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, start, transpose, m_ready;
  logic busy0, done0, busy1, done1;
  transpose_read_streamer_if bus0();
  transpose_read_streamer_if bus1();

  transpose_read_streamer #(.RD_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .transpose(transpose),
    .busy(busy0), .done(done0), .bus(bus0)
  );
  transpose_read_streamer #(.RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .transpose(transpose),
    .busy(busy1), .done(done1), .bus(bus1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] st(input logic [1:0] r, input logic [1:0] c);
    return {2'b00, r, 2'b00, c};
  endfunction

  assign bus0.rd_data = st(bus0.rd_row, bus0.rd_col);
  always @(posedge clk) bus1.rd_data <= st(bus1.rd_row, bus1.rd_col);
  assign bus0.m_ready = m_ready;
  assign bus1.m_ready = m_ready;

  logic [1:0] mv, rden, mlast, bsy, dne;
  logic [7:0] md [2];
  logic [1:0] mrow [2], mcol [2], rrow [2], rcol [2];
  assign mv = {bus1.m_valid, bus0.m_valid};
  assign rden = {bus1.rd_en, bus0.rd_en};
  assign mlast = {bus1.m_last, bus0.m_last};
  assign bsy = {busy1, busy0};
  assign dne = {done1, done0};
  assign md[0] = bus0.m_data;
  assign md[1] = bus1.m_data;
  assign mrow[0] = bus0.m_row;
  assign mrow[1] = bus1.m_row;
  assign mcol[0] = bus0.m_col;
  assign mcol[1] = bus1.m_col;
  assign rrow[0] = bus0.rd_row;
  assign rrow[1] = bus1.rd_row;
  assign rcol[0] = bus0.rd_col;
  assign rcol[1] = bus1.rd_col;

  int checks = 0, errors = 0, cyc = 0;
  int hs [2], rdn [2], dn [2], outs [2], fst [2], lst [2];
  logic pl [2], hv [2];
  logic [7:0] held [2];
  logic [7:0] seq0 [16];
  exp_t q0 [$];
  exp_t q1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input int act, input int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  task automatic mon(input int d);
    exp_t e, g;
    bit h;
    int n, qs;
    if (!rst_n) begin
      pl[d] = 1'b0;
      hv[d] = 1'b0;
      outs[d] = 0;
      return;
    end
    h = mv[d] && m_ready;
    chk(dne[d] == pl[d], $sformatf("done_timing%0d", d), dne[d], pl[d]);
    if (dne[d]) chk(!bsy[d], $sformatf("busy_in_done%0d", d), bsy[d], 0);
    if (!rden[d]) chk(rrow[d] == 2'd0 && rcol[d] == 2'd0, $sformatf("idle_addr%0d", d), {rrow[d], rcol[d]}, 0);
    n = outs[d] + int'(rden[d]) - int'(h);
    chk(n <= 2, $sformatf("credit%0d", d), n, 2);
    outs[d] = n;
    if (rden[d]) rdn[d]++;
    if (hv[d]) chk(mv[d] && md[d] == held[d], $sformatf("stable%0d", d), md[d], held[d]);
    if (h) begin
      g = {md[d], mrow[d], mcol[d], mlast[d]};
      qs = d == 0 ? q0.size() : q1.size();
      chk(qs > 0, $sformatf("unexpected%0d", d), qs, 1);
      if (qs > 0) begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk(g == e, $sformatf("stream%0d", d), g, e);
      end
      if (d == 0 && hs[0] < 16) seq0[hs[0]] = md[0];
      hs[d]++;
      if (hs[d] == 1) fst[d] = cyc;
      lst[d] = cyc;
    end
    if (dne[d]) dn[d]++;
    pl[d] = h && mlast[d];
    hv[d] = mv[d] && !m_ready;
    held[d] = md[d];
  endtask

  always @(negedge clk) for (int d = 0; d < 2; d++) mon(d);

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      hs[d] = 0;
      rdn[d] = 0;
      dn[d] = 0;
      fst[d] = 0;
      lst[d] = 0;
    end
  endtask

  task automatic push_exp(input bit tr);
    for (int k = 0; k < 16; k++) begin
      exp_t e;
      e.row = 2'(k / 4);
      e.col = 2'(k % 4);
      e.data = tr ? st(e.col, e.row) : st(e.row, e.col);
      e.last = k == 15;
      q0.push_back(e);
      q1.push_back(e);
    end
  endtask

  task automatic run_pass(input vec_t v);
    bit rp = 1'b0;
    int t;
    clear_stats();
    push_exp(v.tr);
    transpose = v.tr;
    start = 1'b1;
    m_ready = v.hold > 0 ? 1'b0 : 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    transpose = ~v.tr;
    @(negedge clk);
    chk(bsy == 2'b11, "busy_after_start", bsy, 3);
    if (v.hold > 0) begin
      repeat (v.hold - 1) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk(rdn[d] == 2, $sformatf("hold_reads%0d", d), rdn[d], 2);
        chk(mv[d] && md[d] == 8'h00, $sformatf("hold_head%0d", d), {mv[d], md[d]}, 9'h100);
      end
    end
    for (t = 0; t < 400 && !(dn[0] > 0 && dn[1] > 0); t++) begin
      @(posedge clk);
      #1;
      m_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = v.repulse && !rp && hs[0] == 5;
      if (start) rp = 1'b1;
    end
    chk(t < 400, "pass_timeout", t, 400);
    start = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    if (v.repulse) chk(rp, "repulse_sent", rp, 1);
    for (int d = 0; d < 2; d++) begin
      chk(hs[d] == 16, $sformatf("count%0d", d), hs[d], 16);
      chk(dn[d] == 1, $sformatf("done_count%0d", d), dn[d], 1);
      chk((d == 0 ? q0.size() : q1.size()) == 0, $sformatf("leftover%0d", d), d == 0 ? q0.size() : q1.size(), 0);
      if (v.span >= 0) chk(lst[d] - fst[d] == v.span, $sformatf("span%0d", d), lst[d] - fst[d], v.span);
    end
    chk(seq0[1] == v.e1, "second_elem", seq0[1], v.e1);
    chk(seq0[15] == v.e15, "last_elem", seq0[15], v.e15);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl [6];
    int t;
    void'($urandom(32'd20240611));
    tbl[0] = '{tr: 1'b1, rnd: 1'b0, hold: 0,  repulse: 1'b0, e1: 8'h10, e15: 8'h33, span: 15};
    tbl[1] = '{tr: 1'b0, rnd: 1'b0, hold: 0,  repulse: 1'b0, e1: 8'h01, e15: 8'h33, span: 15};
    tbl[2] = '{tr: 1'b1, rnd: 1'b1, hold: 0,  repulse: 1'b0, e1: 8'h10, e15: 8'h33, span: -1};
    tbl[3] = '{tr: 1'b1, rnd: 1'b0, hold: 0,  repulse: 1'b1, e1: 8'h10, e15: 8'h33, span: 15};
    tbl[4] = '{tr: 1'b0, rnd: 1'b1, hold: 0,  repulse: 1'b1, e1: 8'h01, e15: 8'h33, span: -1};
    tbl[5] = '{tr: 1'b1, rnd: 1'b0, hold: 10, repulse: 1'b0, e1: 8'h10, e15: 8'h33, span: -1};
    rst_n = 1'b0;
    start = 1'b0;
    transpose = 1'b0;
    m_ready = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk({mv[d], bsy[d], dne[d], rden[d]} == 4'd0, $sformatf("reset_outs%0d", d), {mv[d], bsy[d], dne[d], rden[d]}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 6; r++) run_pass(tbl[r]);
    clear_stats();
    push_exp(1'b1);
    transpose = 1'b1;
    start = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (t = 0; t < 100 && hs[0] < 7; t++) begin
      @(posedge clk);
      #1;
    end
    chk(hs[0] == 7, "abort_handshakes", hs[0], 7);
    rst_n = 1'b0;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk({mv[d], bsy[d], rden[d]} == 3'd0, $sformatf("abort_outs%0d", d), {mv[d], bsy[d], rden[d]}, 0);
    q0.delete();
    q1.delete();
    repeat (6) @(negedge clk);
    for (int d = 0; d < 2; d++) chk(dn[d] == 0, $sformatf("abort_done%0d", d), dn[d], 0);
    @(posedge clk);
    #1;
    run_pass(tbl[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
